// File: rtl/jk_pkg.sv
// jk_pkg: shared types and constants for the JK flop-bank driver.
// Holds the FSM state encoding, J/K excitation codes and a per-bit helper.
package jk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } state_e;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  localparam int CNT_W = 4;

  // {j,k} needed to move one flop from cur to tgt.
  function automatic logic [1:0] jk_code(
    input logic cur,
    input logic tgt,
    input logic mode
  );
    logic [1:0] c;
    if (cur == tgt)
      c = JK_HOLD;
    else if (mode)
      c = JK_TOGGLE;
    else if (tgt)
      c = JK_SET;
    else
      c = JK_RESET;
    return c;
  endfunction

endpackage

// File: rtl/jk_bank_driver_excite.sv
// jk_excite: combinational J/K excitation for a WIDTH-wide flop bank.
// Ports: cur (present Q), tgt (wanted Q), mode (1 = toggle) -> j, k.
module jk_excite
  import jk_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] tgt,
  input  logic             mode,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  always_comb begin
    j = '0;
    k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {j[i], k[i]} = jk_code(cur[i], tgt[i], mode);
    end
  end

endmodule

// File: rtl/jk_bank_driver.sv
// jk_bank_driver: moves an external negedge JK flop bank to a target word.
// Ports: clk, rst (sync, high); tgt_valid/tgt_ready/tgt_data handshake;
//   j, k drive the bank; q_fb reads it back; busy, done, err, err_mask report.
module jk_bank_driver
  import jk_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SETTLE      = 2,
  parameter int MODE_TOGGLE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q_fb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);
  localparam logic             MODE     = (MODE_TOGGLE != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [WIDTH-1:0] err_mask_q, err_mask_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic [WIDTH-1:0] exc_j, exc_k;
  logic [WIDTH-1:0] diff;

  // Excitation is formed from the live bank state at the accepting edge.
  jk_excite #(
    .WIDTH (WIDTH)
  ) u_excite (
    .cur  (q_fb),
    .tgt  (tgt_data),
    .mode (MODE),
    .j    (exc_j),
    .k    (exc_k)
  );

  assign diff = q_fb ^ tgt_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    j_d        = '0;
    k_d        = '0;
    err_mask_d = err_mask_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tgt_valid && ready_q) begin
          tgt_d   = tgt_data;
          j_d     = exc_j;
          k_d     = exc_k;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        cnt_d   = CNT_INIT;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0)
          state_d = ST_CHECK;
        else
          cnt_d = cnt_q - 1'b1;
      end
      ST_CHECK: begin
        err_mask_d = diff;
        err_d      = |diff;
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tgt_q      <= '0;
      j_q        <= '0;
      k_q        <= '0;
      err_mask_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      j_q        <= j_d;
      k_q        <= k_d;
      err_mask_q <= err_mask_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  assign tgt_ready = ready_q;
  assign j         = j_q;
  assign k         = k_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_mask  = err_mask_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// tb_jk_bank_driver: two drivers (set/reset and toggle mode), each on a
// modelled negedge JK bank; a scoreboard queue holds expected results.
module tb_jk_bank_driver;

  localparam int W  = 8;
  localparam int ST = 2;

  typedef struct {
    logic [W-1:0] mask;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tgt_valid [2];
  logic         tgt_ready [2];
  logic [W-1:0] tgt_data  [2];
  logic [W-1:0] j         [2];
  logic [W-1:0] k         [2];
  logic [W-1:0] q_fb      [2];
  logic         busy      [2];
  logic         done      [2];
  logic         err       [2];
  logic [W-1:0] err_mask  [2];

  logic [W-1:0] bank       [2];
  logic [W-1:0] stuck      [2];
  logic         preset_en  [2];
  logic [W-1:0] preset_val [2];

  exp_t sb [$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    jk_bank_driver #(
      .WIDTH       (W),
      .SETTLE      (ST),
      .MODE_TOGGLE (g)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .tgt_valid (tgt_valid[g]),
      .tgt_ready (tgt_ready[g]),
      .tgt_data  (tgt_data[g]),
      .j         (j[g]),
      .k         (k[g]),
      .q_fb      (q_fb[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .err       (err[g]),
      .err_mask  (err_mask[g])
    );
  end

  function automatic logic [W-1:0] jk_next(
    input logic [W-1:0] q, input logic [W-1:0] jj, input logic [W-1:0] kk
  );
    logic [W-1:0] n;
    for (int i = 0; i < W; i++) begin
      case ({jj[i], kk[i]})
        2'b00:   n[i] = q[i];
        2'b01:   n[i] = 1'b0;
        2'b10:   n[i] = 1'b1;
        default: n[i] = ~q[i];
      endcase
    end
    return n;
  endfunction

  // Returns {j,k}: changing bits get set/reset, or toggle in mode 1.
  function automatic logic [2*W-1:0] exc(
    input logic [W-1:0] cur, input logic [W-1:0] tgt, input int mode
  );
    logic [W-1:0] chg;
    chg = cur ^ tgt;
    if (mode != 0) return {chg, chg};
    return {chg & tgt, chg & ~tgt};
  endfunction

  // Bank flops update on the falling edge of the shared clock.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (preset_en[g]) bank[g] <= preset_val[g];
      else bank[g] <= jk_next(bank[g], j[g], k[g]);
    end
  end

  always_comb begin
    for (int g = 0; g < 2; g++) q_fb[g] = bank[g] & ~stuck[g];
  end

  task automatic preset(input int g, input logic [W-1:0] v);
    preset_val[g] = v;
    preset_en[g]  = 1'b1;
    @(negedge clk); #1;
    preset_en[g]  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      vectors++;
      if ({j[g], k[g], err_mask[g]} !== '0 ||
          {tgt_ready[g], busy[g], done[g], err[g]} !== 4'b1000) begin
        miscompares++;
        $display("FAIL reset dut%0d j=%h k=%h m=%h rdy/busy/done/err=%b%b%b%b want 0 0 0 1000",
                 g, j[g], k[g], err_mask[g], tgt_ready[g], busy[g], done[g], err[g]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_op(input int g, input logic [W-1:0] tgt, input string nm);
    logic [W-1:0]   ej, ek, fq;
    logic [2*W-1:0] jk;
    exp_t           e;
    int             n;
    bit             seen;
    vectors++;
    if (tgt_ready[g] !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_before got=%b want=1", nm, tgt_ready[g]);
    end
    jk = exc(q_fb[g], tgt, g);
    ej = jk[2*W-1:W];
    ek = jk[W-1:0];
    fq = jk_next(bank[g], ej, ek) & ~stuck[g];
    e.mask = fq ^ tgt;
    e.err  = |e.mask;
    sb.push_back(e);
    tgt_data[g]  = tgt;
    tgt_valid[g] = 1'b1;
    @(posedge clk); #1;
    tgt_valid[g] = 1'b0;
    vectors++;
    if (j[g] !== ej || k[g] !== ek || busy[g] !== 1'b1) begin
      miscompares++;
      $display("FAIL %s drive j=%h k=%h busy=%b want j=%h k=%h busy=1",
               nm, j[g], k[g], busy[g], ej, ek);
    end
    n = 0;
    seen = 0;
    while (!seen && n < ST + 8) begin
      @(posedge clk); #1;
      n++;
      if (done[g]) begin
        seen = 1;
        e = sb.pop_front();
        vectors++;
        if (n + 1 != ST + 3 || err[g] !== e.err || err_mask[g] !== e.mask ||
            tgt_ready[g] !== 1'b1) begin
          miscompares++;
          $display("FAIL %s done cyc=%0d err=%b mask=%h rdy=%b want cyc=%0d err=%b mask=%h rdy=1",
                   nm, n + 1, err[g], err_mask[g], tgt_ready[g], ST + 3, e.err, e.mask);
        end
      end else begin
        vectors++;
        if (j[g] !== '0 || k[g] !== '0 || tgt_ready[g] !== 1'b0) begin
          miscompares++;
          $display("FAIL %s hold cyc=%0d j=%h k=%h rdy=%b want 00 00 0",
                   nm, n + 1, j[g], k[g], tgt_ready[g]);
        end
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout no done within %0d cycles", nm, ST + 8);
      if (sb.size() > 0) void'(sb.pop_front());
    end
  endtask

  task automatic test_set_reset();
    preset(0, 8'h00);
    run_op(0, 8'hA5, "set_reset");
  endtask

  task automatic test_toggle();
    preset(1, 8'hA5);
    run_op(1, 8'h5A, "toggle");
    vectors++;
    if (q_fb[1] !== 8'h5A) begin
      miscompares++;
      $display("FAIL toggle_readback got=%h want=5a", q_fb[1]);
    end
  endtask

  task automatic test_same_target();
    preset(0, 8'h3C);
    run_op(0, 8'h3C, "same_target");
  endtask

  task automatic test_stuck_bit();
    stuck[0] = 8'h01;
    preset(0, 8'h00);
    run_op(0, 8'h01, "stuck_bit");
  endtask

  task automatic test_reset_mid();
    int n;
    bit bad;
    vectors++;
    if (err_mask[0] !== 8'h01) begin
      miscompares++;
      $display("FAIL reset_mid_premask got=%h want=01", err_mask[0]);
    end
    tgt_data[0]  = 8'h55;
    tgt_valid[0] = 1'b1;
    @(posedge clk); #1;
    tgt_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if (j[0] !== '0 || k[0] !== '0 || busy[0] !== 1'b0 ||
        tgt_ready[0] !== 1'b1 || err_mask[0] !== '0 || done[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid j=%h k=%h busy=%b rdy=%b mask=%h done=%b want 00 00 0 1 00 0",
               j[0], k[0], busy[0], tgt_ready[0], err_mask[0], done[0]);
    end
    bad = 0;
    for (n = 0; n < ST + 4; n++) begin
      @(posedge clk); #1;
      if (done[0] !== 1'b0 || err[0] !== 1'b0) bad = 1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL reset_mid_nodone got=pulse want=none");
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]   ej, ek, fq1, fq2;
    logic [2*W-1:0] jk;
    exp_t           e;
    int             low;
    int             n;
    bit             seen;
    stuck[0] = 8'h00;
    preset(0, 8'h00);
    jk  = exc(q_fb[0], 8'h0F, 0);
    fq1 = jk_next(bank[0], jk[2*W-1:W], jk[W-1:0]);
    e.mask = fq1 ^ 8'h0F;
    e.err  = |e.mask;
    sb.push_back(e);
    tgt_data[0]  = 8'h0F;
    tgt_valid[0] = 1'b1;
    @(posedge clk); #1;
    tgt_data[0] = 8'hF0;
    low = 0;
    while (tgt_ready[0] !== 1'b1 && low < ST + 8) begin
      low++;
      @(posedge clk); #1;
    end
    e = sb.pop_front();
    vectors++;
    if (low != ST + 2 || done[0] !== 1'b1 || err_mask[0] !== e.mask || err[0] !== e.err) begin
      miscompares++;
      $display("FAIL b2b_first low=%0d done=%b mask=%h err=%b want low=%0d done=1 mask=%h err=%b",
               low, done[0], err_mask[0], err[0], ST + 2, e.mask, e.err);
    end
    jk = exc(fq1, 8'hF0, 0);
    ej = jk[2*W-1:W];
    ek = jk[W-1:0];
    fq2 = jk_next(fq1, ej, ek);
    e.mask = fq2 ^ 8'hF0;
    e.err  = |e.mask;
    sb.push_back(e);
    @(posedge clk); #1;
    tgt_valid[0] = 1'b0;
    vectors++;
    if (busy[0] !== 1'b1 || tgt_ready[0] !== 1'b0 || j[0] !== ej || k[0] !== ek) begin
      miscompares++;
      $display("FAIL b2b_accept busy=%b rdy=%b j=%h k=%h want 1 0 j=%h k=%h",
               busy[0], tgt_ready[0], j[0], k[0], ej, ek);
    end
    seen = 0;
    n = 0;
    while (!seen && n < ST + 8) begin
      @(posedge clk); #1;
      n++;
      if (done[0]) seen = 1;
    end
    e = sb.pop_front();
    vectors++;
    if (!seen || n + 1 != ST + 3 || err_mask[0] !== e.mask || err[0] !== e.err) begin
      miscompares++;
      $display("FAIL b2b_second seen=%b cyc=%0d mask=%h err=%b want 1 cyc=%0d mask=%h err=%b",
               seen, n + 1, err_mask[0], err[0], ST + 3, e.mask, e.err);
    end
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      tgt_valid[g]  = 1'b0;
      tgt_data[g]   = '0;
      stuck[g]      = '0;
      preset_en[g]  = 1'b0;
      preset_val[g] = '0;
    end
    test_reset();
    test_set_reset();
    test_toggle();
    test_same_target();
    test_stuck_bit();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
